// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared constants for the ROB allocation / ID-stage control slice.
package rob_alloc_ctrl_pkg;

    localparam int unsigned ROB_DEPTH_DFLT      = 8;
    localparam int unsigned RECOVER_CYCLES_DFLT = 2;

    // Recover counter covers RECOVER_CYCLES up to 15
    localparam int unsigned RCNT_W = 4;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

endpackage

// File: rtl/rob_alloc_ctrl_rob_ptr.sv
// Wrap-around ROB pointer with enable and synchronous clear.
module rob_alloc_ctrl_rob_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Depth is a power of two, so natural overflow provides the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB tag allocation, occupancy tracking and ID-register stall/flush control
// with a fixed-length recovery sequence after a flush.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ROB_DEPTH      = ROB_DEPTH_DFLT,
    parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DFLT,
    localparam int unsigned PW            = $clog2(ROB_DEPTH),
    localparam int unsigned CW            = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_en,
    input  logic          dec_valid,
    input  logic          ds_stall,
    input  logic          flush,
    input  logic          commit_valid,
    input  logic [PW-1:0] commit_rob,
    output logic [PW-1:0] alloc_rob,
    output logic          id_stall,
    output logic          id_flush,
    output logic [CW-1:0] rob_count,
    output logic          rob_full,
    output logic          rob_empty,
    output logic          commit_err
);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_nxt;
    logic [PW-1:0]     head;
    logic              in_recover;
    logic              ptr_clr;
    logic              do_alloc;
    logic              commit_try;
    logic              do_commit;
    logic              commit_bad;

    assign in_recover = (state == ST_RECOVER);
    assign rob_full   = (rob_count == CW'(ROB_DEPTH));
    assign rob_empty  = (rob_count == '0);
    assign id_stall   = ds_stall | rob_full | flush | in_recover;
    assign id_flush   = flush | in_recover;

    // Flush outranks commit/alloc; commits during flush or recovery are dropped silently
    assign ptr_clr    = cpu_en & flush;
    assign do_alloc   = cpu_en & dec_valid & ~id_stall;
    assign commit_try = cpu_en & commit_valid & ~flush & ~in_recover;
    assign do_commit  = commit_try & ~rob_empty & (commit_rob == head);
    assign commit_bad = commit_try & ~do_commit;

    rob_alloc_ctrl_rob_ptr #(.W(PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (do_commit),
        .clr   (ptr_clr),
        .ptr   (head)
    );

    rob_alloc_ctrl_rob_ptr #(.W(PW)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (do_alloc),
        .clr   (ptr_clr),
        .ptr   (alloc_rob)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Recovery sequencing; a flush in either state restarts the count
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        if (cpu_en) begin
            if (flush) begin
                state_nxt = ST_RECOVER;
                rcnt_nxt  = RCNT_W'(RECOVER_CYCLES - 1);
            end else if (in_recover) begin
                if (rcnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    rcnt_nxt = rcnt - RCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob_count <= '0;
        end else if (ptr_clr) begin
            rob_count <= '0;
        end else begin
            rob_count <= rob_count + CW'(do_alloc) - CW'(do_commit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_err <= 1'b0;
        end else if (commit_bad) begin
            commit_err <= 1'b1;
        end
    end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

Allocation and pipeline-control sequencer for the decode/ID stage. It hands out reorder-buffer (ROB) tags in program order to each instruction entering the ID pipeline register, and tracks occupancy against in-order commits. It drives that register's `id_stall` and `id_flush` controls, including a fixed-length recovery sequence after a pipeline flush. It sits between the decoder/ID register and the ROB/commit logic.

## Interface
Parameters:
- `ROB_DEPTH`, default `` `ROB_DEPTH `` (8): number of ROB entries; must be a power of two, ≥2.
- `RECOVER_CYCLES`, default 2: cycles that `id_flush`/`id_stall` stay asserted after the flush-request cycle; range 1..15.

Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Ports (`PW = $clog2(ROB_DEPTH)`):
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_en`  in  1  global enable; low freezes all state
- `dec_valid`  in  1  decoder presents an instruction for the ID register
- `ds_stall`  in  1  downstream (dispatch/issue) back-pressure
- `flush`  in  1  mispredict/exception flush request, single- or multi-cycle
- `commit_valid`  in  1  ROB retires its head entry this cycle
- `commit_rob`  in  PW  tag being retired
- `alloc_rob`  out  PW  tag for the instruction now entering the ID register (= tail pointer)
- `id_stall`  out  1  hold the ID register
- `id_flush`  out  1  clear the ID register
- `rob_count`  out  PW+1  occupied entries
- `rob_full`  out  1  `rob_count == ROB_DEPTH`
- `rob_empty`  out  1  `rob_count == 0`
- `commit_err`  out  1  sticky protocol-violation flag

## Operation
- State: `head`, `tail` (PW bits, wrap modulo `ROB_DEPTH`), `rob_count`, FSM {RUN, RECOVER}, recover counter, `commit_err`.
- `id_stall = ds_stall | rob_full | flush | (state==RECOVER)`, combinational.
- `id_flush = flush | (state==RECOVER)`, combinational.
- Allocation happens when `cpu_en & dec_valid & !id_stall`. The edge then increments `tail`.
- Commit is legal when `cpu_en & commit_valid & !rob_empty & commit_rob==head`. The edge then increments `head`.
- An illegal commit (empty ROB or tag ≠ `head`) is ignored and sets `commit_err`. `commit_err` clears only on reset.
- `rob_count` next value = count + alloc − legal commit. A simultaneous alloc and commit leaves the count unchanged.
- Full stall uses the registered count only; there is no same-cycle bypass from a commit.
- FSM RUN: on `flush` (with `cpu_en`), `head`/`tail`/`rob_count` go to 0, the recover counter loads `RECOVER_CYCLES−1`, and the FSM enters RECOVER.
- FSM RECOVER: allocation is blocked and commits are ignored without setting `commit_err`. The counter decrements each cycle; at 0 the FSM returns to RUN.
- A `flush` arriving during RECOVER zeroes the pointers again and reloads the counter.
- Priority: reset > `!cpu_en` (hold) > `flush` > commit/alloc.

## Timing
- Reset values: `head=tail=0`, count 0, RUN, `commit_err=0`. Outputs under reset: `alloc_rob=0`, `rob_empty=1`, `rob_full=0`, `id_flush=0`, `id_stall=ds_stall|flush`.
- `alloc_rob` is valid in the same cycle as the allocation, and the ID register captures it at that edge. The next tag is visible the following cycle.
- Flush asserted in cycle N:
  - `id_flush`/`id_stall` are high in N and N+1..N+`RECOVER_CYCLES`.
  - The first possible allocation is in cycle N+`RECOVER_CYCLES`+1, with tag 0.
- Wrap-around: `tail` goes from `ROB_DEPTH−1` to 0 and is disambiguated by `rob_count`, not by pointer compare.
- A reset asserted mid-RECOVER aborts the sequence immediately (asynchronous).

## Structure
- `ROB_DEPTH` and the PW-derived tag width live in `define.v`, shared with the ID register and ROB.
- FSM encoding and the recover-counter width are local constants.
- The one natural sub-module is `rob_ptr`: a wrap-around pointer with enable and synchronous clear, instantiated for `head` and `tail`.

## Test plan
- Reset, then `dec_valid=1` for 9 cycles with no commits → tags 0..7 issued; `rob_full=1` after the 8th allocation; the 9th cycle has `id_stall=1` and `tail` unchanged.
- From full, commit tag 0 → next cycle count 7, `id_stall=0`, next allocation gets tag 0 (wrap).
- Count 4, head 2: simultaneous alloc + commit tag 2 → count stays 4, head 3, tail +1.
- Count 5, `flush` pulse in cycle N (`RECOVER_CYCLES=2`) → `id_flush` high N..N+2, count 0, first allocation at N+3 with tag 0.
- Commit on empty ROB, then commit tag 3 while head is 1 → `commit_err` rises and stays high; count and head unchanged.
- `cpu_en=0` with `dec_valid`, `commit_valid` and `flush` all high → no pointer, count or FSM change.
